// File: rtl/word_demux3.sv
// Three-way word demultiplexer: each destination is a one-entry holding slot with
// valid/ready handshake and a wrapping delivery counter.
module word_demux3 #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             c1,
  input  logic             c2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] w1,
  output logic [WIDTH-1:0] w2,
  output logic [WIDTH-1:0] w3,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3,
  output logic [CNT_W-1:0] n1,
  output logic [CNT_W-1:0] n2,
  output logic [CNT_W-1:0] n3
);

  logic [2:0]                       sel;
  logic [2:0]                       r_vec;
  logic                             acc;
  logic [2:0]                       v_q, v_d;
  logic [2:0][WIDTH-1:0]            w_q, w_d;
  logic [2:0][CNT_W-1:0]            n_q, n_d;

  assign r_vec = {r3, r2, r1};

  // c2 has priority and selects slot 0 (w1) regardless of c1.
  always_comb begin
    sel = 3'b000;
    if (c2) begin
      sel = 3'b001;
    end else if (c1) begin
      sel = 3'b100;
    end else begin
      sel = 3'b010;
    end
  end

  // A slot can take a word if it is empty or is being drained on this same edge.
  assign in_ready = |(sel & (~v_q | r_vec));
  assign acc      = in_valid & in_ready;

  always_comb begin
    v_d = v_q;
    w_d = w_q;
    n_d = n_q;
    for (int k = 0; k < 3; k++) begin
      v_d[k] = (acc & sel[k]) | (v_q[k] & ~r_vec[k]);
      if (acc && sel[k]) begin
        w_d[k] = din;
      end
      if (v_q[k] && r_vec[k]) begin
        n_d[k] = n_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      w_q <= '0;
      n_q <= '0;
    end else begin
      v_q <= v_d;
      w_q <= w_d;
      n_q <= n_d;
    end
  end

  assign v1 = v_q[0];
  assign v2 = v_q[1];
  assign v3 = v_q[2];
  assign w1 = w_q[0];
  assign w2 = w_q[1];
  assign w3 = w_q[2];
  assign n1 = n_q[0];
  assign n2 = n_q[1];
  assign n3 = n_q[2];

endmodule

// File: doc/word_demux3.md
WORD_DEMUX3 -- requirements
Module: word_demux3

Interface
REQ-001 Parameter WIDTH, default 3, is the data word width in bits.
REQ-002 Parameter CNT_W, default 8, is the width of each per-destination delivery counter.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port din, input, WIDTH bits: source word.
REQ-006 Port c1, input, 1 bit: destination select, low bit.
REQ-007 Port c2, input, 1 bit: destination select, priority bit.
REQ-008 Port in_valid, input, 1 bit: din, c1 and c2 are valid.
REQ-009 Port in_ready, output, 1 bit: the word is accepted this cycle if in_valid is also high.
REQ-010 Ports w1, w2 and w3, outputs, WIDTH bits each: registered destination words.
REQ-011 Ports v1, v2 and v3, outputs, 1 bit each: the corresponding wK holds an undelivered word.
REQ-012 Ports r1, r2 and r3, inputs, 1 bit each: the consumer of wK takes the word this cycle.
REQ-013 Ports n1, n2 and n3, outputs, CNT_W bits each: count of words delivered on wK.

Function
REQ-014 Destination decode SHALL be: c2=1 selects w1 and ignores c1; c2=0 with c1=0 selects w2; c2=0 with c1=1 selects w3.
REQ-015 Each destination SHALL contain a one-entry holding slot made of a data register wK and a full flag vK.
REQ-016 in_ready SHALL be combinational and equal to (NOT vSEL) OR rSEL, where SEL is the decoded destination.
REQ-017 in_ready SHALL NOT depend on in_valid.
REQ-018 An accept is in_valid AND in_ready on a rising edge.
REQ-019 On an accept, wSEL SHALL load din and vSEL SHALL be 1 on the next cycle; latency from accept to vSEL high is 1 cycle.
REQ-020 A delivery on destination K is vK AND rK on a rising edge.
REQ-021 A delivery SHALL clear vK on the next cycle, unless the same edge also accepts a word for K.
REQ-022 On a delivery, nK SHALL increment by 1 and SHALL wrap from 2^CNT_W-1 to 0.
REQ-023 Simultaneous delivery and accept on the same K: vK SHALL stay 1, wK SHALL take the new din, and nK SHALL increment.
REQ-024 While vK=0, wK SHALL hold its last value and rK SHALL be ignored, with no count change.
REQ-025 Slots SHALL be independent: a full, stalled slot SHALL NOT block accepts to other slots.
REQ-026 Deliveries on different slots in the same cycle SHALL all take effect.
REQ-027 Slots SHALL NOT change between accepts and deliveries; word order per destination SHALL be preserved, since each slot holds at most one word.
REQ-028 Change of c1 or c2 while in_valid=1 and in_ready=0 is permitted; in_ready SHALL re-evaluate against the new destination.
REQ-029 The block SHALL NOT drop, duplicate or misroute words under any r1..r3 pattern.

Reset
REQ-030 While rst=1 on a rising edge, the following SHALL be 0 on the next cycle: v1..v3, w1..w3 and n1..n3.
REQ-031 rst SHALL override a simultaneous accept or delivery, and any word held at reset SHALL be discarded.
REQ-032 in_ready SHALL be 1 in the first cycle after reset, for any select value.

Verification
REQ-033 Route test: after reset, send din=3'b101 with c2=1, din=3'b010 with c2=0/c1=0, and din=3'b111 with c2=0/c1=1, one per cycle, holding r1..r3=0 -> w1=101, w2=010 and w3=111, with v1..v3 each high from the cycle after its accept.
REQ-034 Backpressure test: with v2=1 and r2=0, present a word for w2 -> in_ready=0 and w2 unchanged; then present a word for w3 in the same state -> accepted.
REQ-035 Pass-through test: with v1=1 and r1=1, accept din=3'b011 for w1 on the same edge -> v1 stays 1, w1=011 and n1 increments by 1.
REQ-036 Counter wrap test: with CNT_W=8, make 256 deliveries on w3 -> n3 returns to 0, and n1 and n2 are unchanged.
REQ-037 Reset test: assert rst mid-stream with v1..v3=1 and an accept pending -> next cycle all v=0, all w=0, all n=0 and in_ready=1.
REQ-038 Random test: drive random in_valid, selects and r1..r3 for 10k cycles against a scoreboard -> no loss, duplication or misroute, and each nK equals its scoreboard count mod 2^CNT_W.
